// File: rtl/dec2bin_seq.sv
// Sequential decimal-to-binary converter: folds NDIGITS digits MSD-first, one per clock.
// Build option: define DEC2BIN_SAT_EN to saturate bin_o on overflow (default build wraps).
//
// state | meaning
// IDLE  | ready_o high, waiting for a digit set
// CONV  | folding one captured digit per clock into the accumulator
// DONE  | result held on bin_o/err_o/ovf_o until the consumer takes it

module dec2bin_seq #(
  parameter int NDIGITS = 3,
  parameter int DIG_W   = 8,
  parameter int BIN_W   = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIG_W-1:0] dec_i [NDIGITS],
  input  logic             valid_i,
  output logic             ready_o,
  output logic [BIN_W-1:0] bin_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             err_o,
  output logic             ovf_o
);

  localparam int ACC_MIN = $clog2(10 ** NDIGITS);
  localparam int ACC_W   = (ACC_MIN > BIN_W + 4) ? ACC_MIN : BIN_W + 4;
  localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [ACC_W-1:0] BIN_MAX = {{(ACC_W-BIN_W){1'b0}}, {BIN_W{1'b1}}};
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIGITS - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(9);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [DIG_W-1:0] dig_q [NDIGITS];
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic             err_q;

  logic [DIG_W-1:0] cur_dig;
  logic [ACC_W-1:0] acc_nxt;
  logic             err_nxt;
  logic             ovf_nxt;
  logic [BIN_W-1:0] bin_nxt;

  // Full lane width is compared, so out-of-range digits are flagged rather than truncated.
  always_comb begin
    cur_dig = dig_q[idx];
    acc_nxt = (acc << 3) + (acc << 1) + ACC_W'(cur_dig);
    err_nxt = err_q | (cur_dig > DIG_MAX);
    ovf_nxt = 1'b0;
    bin_nxt = acc_nxt[BIN_W-1:0];
    if (err_nxt) begin
      bin_nxt = '0;
    end else if (acc_nxt > BIN_MAX) begin
      ovf_nxt = 1'b1;
`ifdef DEC2BIN_SAT_EN
      bin_nxt = '1;
`else
      bin_nxt = acc_nxt[BIN_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      bin_o   <= '0;
      err_o   <= 1'b0;
      ovf_o   <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NDIGITS; i++) dig_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          if (valid_i && ready_o) begin
            dig_q   <= dec_i;
            acc     <= '0;
            err_q   <= 1'b0;
            idx     <= IDX_TOP;
            ready_o <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          ready_o <= 1'b0;
          acc     <= acc_nxt;
          err_q   <= err_nxt;
          if (idx == '0) begin
            bin_o   <= bin_nxt;
            err_o   <= err_nxt;
            ovf_o   <= ovf_nxt;
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          ready_o <= 1'b0;
          if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec2bin_seq.sv
// Directed bench for dec2bin_seq: conversions, overflow, errors, backpressure and abort.
// Expected overflow results follow DEC2BIN_SAT_EN when the bench is built with it.

module tb_dec2bin_seq;

  localparam int NDIGITS = 3;
  localparam int DIG_W   = 8;
  localparam int BIN_W   = 9;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [DIG_W-1:0] dec_i [NDIGITS];
  logic             valid_i;
  logic             ready_o;
  logic [BIN_W-1:0] bin_o;
  logic             valid_o;
  logic             ready_i;
  logic             err_o;
  logic             ovf_o;

  int vectors = 0;
  int miscompares = 0;

  dec2bin_seq #(.NDIGITS(NDIGITS), .DIG_W(DIG_W), .BIN_W(BIN_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .dec_i   (dec_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .bin_o   (bin_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .err_o   (err_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one conversion with ready_i high; lat = edges from accept to valid_o (99 on timeout).
  task automatic do_conv(input int d2, input int d1, input int d0,
                         output int lat, output int b, output int e, output int o);
    int n;
    n = 0;
    while (!ready_o && n < 20) begin
      step();
      n++;
    end
    ready_i  = 1'b1;
    dec_i[2] = DIG_W'(d2);
    dec_i[1] = DIG_W'(d1);
    dec_i[0] = DIG_W'(d0);
    valid_i  = 1'b1;
    step();
    valid_i = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (valid_o) begin
        lat = i;
        break;
      end
    end
    b = int'(bin_o);
    e = int'(err_o);
    o = int'(ovf_o);
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < NDIGITS; i++) dec_i[i] = '0;
    step();
    step();
    rst_i = 1'b0;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    vectors++; if (bin_o !== 9'd0) begin miscompares++; $display("FAIL reset_bin: got %0d want 0", bin_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_o); end
    vectors++; if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
  endtask

  task automatic test_convert();
    int vec [7][3] = '{'{1,2,3}, '{5,1,1}, '{0,0,0}, '{0,0,7}, '{0,4,2}, '{9,0,9}, '{2,5,5}};
    int exp_b [7] = '{123, 511, 0, 7, 42, 909 % 512, 255};
    int exp_o [7] = '{0, 0, 0, 0, 0, 1, 0};
    int lat, b, e, o, eb;
    for (int t = 0; t < 7; t++) begin
      do_conv(vec[t][0], vec[t][1], vec[t][2], lat, b, e, o);
      eb = exp_b[t];
`ifdef DEC2BIN_SAT_EN
      if (exp_o[t] == 1) eb = 511;
`endif
      vectors++; if (lat != 3) begin miscompares++; $display("FAIL conv%0d_latency: got %0d want 3", t, lat); end
      vectors++; if (b != eb) begin miscompares++; $display("FAIL conv%0d_bin: got %0d want %0d", t, b, eb); end
      vectors++; if (e != 0) begin miscompares++; $display("FAIL conv%0d_err: got %0d want 0", t, e); end
      vectors++; if (o != exp_o[t]) begin miscompares++; $display("FAIL conv%0d_ovf: got %0d want %0d", t, o, exp_o[t]); end
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL conv%0d_ready_after_drain: got %b want 1", t, ready_o); end
    end
  endtask

  task automatic test_overflow();
    int lat, b, e, o;
    int sat_512, sat_999;
`ifdef DEC2BIN_SAT_EN
    sat_512 = 511;
    sat_999 = 511;
`else
    sat_512 = 0;
    sat_999 = 487;
`endif
    do_conv(5, 1, 2, lat, b, e, o);
    vectors++; if (o != 1) begin miscompares++; $display("FAIL ovf512_flag: got %0d want 1", o); end
    vectors++; if (b != sat_512) begin miscompares++; $display("FAIL ovf512_bin: got %0d want %0d", b, sat_512); end
    vectors++; if (e != 0) begin miscompares++; $display("FAIL ovf512_err: got %0d want 0", e); end
    do_conv(9, 9, 9, lat, b, e, o);
    vectors++; if (o != 1) begin miscompares++; $display("FAIL ovf999_flag: got %0d want 1", o); end
    vectors++; if (b != sat_999) begin miscompares++; $display("FAIL ovf999_bin: got %0d want %0d", b, sat_999); end
  endtask

  task automatic test_error();
    int vec [4][3] = '{'{1,10,3}, '{0,0,255}, '{12,0,0}, '{9,9,10}};
    int lat, b, e, o;
    for (int t = 0; t < 4; t++) begin
      do_conv(vec[t][0], vec[t][1], vec[t][2], lat, b, e, o);
      vectors++; if (e != 1) begin miscompares++; $display("FAIL err%0d_flag: got %0d want 1", t, e); end
      vectors++; if (b != 0) begin miscompares++; $display("FAIL err%0d_bin: got %0d want 0", t, b); end
      vectors++; if (o != 0) begin miscompares++; $display("FAIL err%0d_ovf: got %0d want 0", t, o); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    ready_i  = 1'b0;
    dec_i[2] = 8'd1;
    dec_i[1] = 8'd2;
    dec_i[0] = 8'd3;
    valid_i  = 1'b1;
    step();
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_valid_timeout: got %b want 1", valid_o); end
    dec_i[2] = 8'd9;
    dec_i[1] = 8'd9;
    dec_i[0] = 8'd9;
    valid_i  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL bp%0d_valid: got %b want 1", c, valid_o); end
      vectors++; if (bin_o !== 9'd123) begin miscompares++; $display("FAIL bp%0d_bin: got %0d want 123", c, bin_o); end
      vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL bp%0d_ready: got %b want 0", c, ready_o); end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_drain_valid: got %b want 0", valid_o); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_drain_ready: got %b want 1", ready_o); end
    step();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_no_stray_result: got %b want 0", valid_o); end
  endtask

  task automatic test_reset_abort();
    int lat, b, e, o;
    ready_i  = 1'b1;
    dec_i[2] = 8'd9;
    dec_i[1] = 8'd9;
    dec_i[0] = 8'd9;
    valid_i  = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", ready_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b want 0", valid_o); end
    vectors++; if (bin_o !== 9'd0) begin miscompares++; $display("FAIL abort_bin: got %0d want 0", bin_o); end
    vectors++; if (err_o !== 1'b0 || ovf_o !== 1'b0) begin miscompares++; $display("FAIL abort_flags: got err=%b ovf=%b want 0 0", err_o, ovf_o); end
    do_conv(0, 4, 2, lat, b, e, o);
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL post_abort_latency: got %0d want 3", lat); end
    vectors++; if (b != 42) begin miscompares++; $display("FAIL post_abort_bin: got %0d want 42", b); end
    vectors++; if (e != 0 || o != 0) begin miscompares++; $display("FAIL post_abort_flags: got err=%0d ovf=%0d want 0 0", e, o); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_error();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dec2bin_seq.md
Name: dec2bin_seq

Overview:
- Sequential decimal-to-binary converter; the inverse of the team's binary-to-decimal display path.
- Accepts NDIGITS decimal digit values in one handshake and folds them MSD-first into a binary value, one digit per clock (acc = acc*10 + digit).
- Sits between keypad/digit-entry logic and the adder datapath.
- Uses valid/ready on both input and output.

Parameters:
- NDIGITS, 3: number of decimal digits per conversion, index NDIGITS-1 = most significant.
- DIG_W, 8: width of each digit input lane.
- BIN_W, 9: width of binary result.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- dec_i  in  [DIG_W-1:0] x NDIGITS (unpacked array)  digit values; dec_i[NDIGITS-1] is MSD.
- valid_i  in  1  dec_i valid.
- ready_o  out  1  converter can accept.
- bin_o  out  BIN_W  binary result.
- valid_o  out  1  bin_o/err_o/ovf_o valid.
- ready_i  in  1  consumer accepts result.
- err_o  out  1  some digit > 9.
- ovf_o  out  1  true result > 2^BIN_W-1.

Behaviour:
- Clock and reset: one clock, clk_i; rst_i synchronous, active-high.
- Reset values: state=IDLE, ready_o=1, valid_o=0, bin_o=0, err_o=0, ovf_o=0, accumulator=0, digit index=0.
- Reset mid-conversion or with valid_o held: abort, return to reset values on the next edge, discard captured digits.
- Internal accumulator width: ACC_W = ceil(log2(10^NDIGITS)), at least BIN_W+4; it never wraps internally.
- IDLE:
  - ready_o=1, valid_o=0.
  - On an edge with valid_i & ready_o: latch all digits, clear acc/err, index=NDIGITS-1, go to CONV.
- CONV:
  - ready_o=0.
  - Each edge: acc <= acc*10 + dig[index], computed as (acc<<3)+(acc<<1)+dig.
  - If dig[index] > 9, set sticky err.
  - Decrement index; after processing index 0, go to DONE.
- DONE:
  - valid_o=1, ready_o=0.
  - bin_o, err_o and ovf_o are held stable until valid_o & ready_i on an edge, then go to IDLE.
- Latency: accept edge k → valid_o high after edge k+NDIGITS (3 cycles for the default). Throughput is one conversion per NDIGITS+2 cycles with ready_i tied high.
- ready_o is low in CONV and DONE; input is not accepted in the same cycle a result drains.
- Result rules on entering DONE:
  - err=1: bin_o=0, ovf_o=0, err_o=1. Error takes priority over overflow.
  - else acc > 2^BIN_W-1: ovf_o=1; bin_o per the optional feature.
  - else bin_o = acc[BIN_W-1:0], err_o=0, ovf_o=0.
- Digit values 10..2^DIG_W-1 are all errors; upper lane bits are never silently truncated.
- ready_i high before valid_o is ignored; ready_i low in DONE stalls indefinitely.
- valid_i toggling or dec_i changing during CONV or DONE has no effect on the result in progress.

Optional Feature:
- DEC2BIN_SAT_EN defined: on overflow, bin_o saturates to all ones (511 for BIN_W=9).
- Not defined: bin_o = acc mod 2^BIN_W (wrap).
- ovf_o is asserted identically in both builds.

Test Plan:
- Digits {1,2,3} (MSD first), ready_i=1 → valid_o exactly 3 cycles after the accept edge; bin_o=123, err_o=0, ovf_o=0.
- Digits {5,1,1} → bin_o=511, ovf_o=0. Digits {0,0,0} → bin_o=0. Digits {0,0,7} → bin_o=7.
- Digits {5,1,2} → ovf_o=1; bin_o=511 with DEC2BIN_SAT_EN, bin_o=0 without. Digits {9,9,9} → ovf_o=1; bin_o=511 (sat) or 999 mod 512 = 487 (wrap).
- Digits {1,10,3} and {0,0,255} → err_o=1, bin_o=0, ovf_o=0. Digits {12,0,0} → err_o=1, ovf_o=0 (error priority).
- Backpressure: ready_i=0 for 5 cycles in DONE → valid_o and bin_o=123 held stable, ready_o=0, new valid_i ignored; ready_i=1 → drain, ready_o=1 the next cycle.
- rst_i asserted one cycle into CONV → next edge all outputs at reset values. A following conversion of {0,4,2} → bin_o=42 with no residue from the aborted run.
